// File: rtl/fmul16_arbiter.sv
// ---------------------------------------------------------------------------
// fmul16_arbiter
//
// Purpose:
//   Shares one external combinational FP16 multiplier between NUM_REQ
//   requesters. Requests are arbitrated round-robin. Only one operation is in
//   flight at a time. Each operation walks IDLE -> ISSUE -> RESP. The arbiter
//   only moves operands and the product around and never inspects their
//   contents, so NaN, Inf, zero and subnormal values pass through unchanged.
//
// Parameters:
//   NUM_REQ     number of requesters (2..8)
//   REQ_ID_W    requester index width, derived from NUM_REQ
//
// Ports:
//   CLK, RST      rising-edge clock, asynchronous active-high reset
//   req_valid     per-requester request
//   req_ready     per-requester accept (one-hot or zero, combinational in IDLE)
//   req_a, req_b  packed operands, requester i uses bits [16i+15:16i]
//   mul_a, mul_b  operands driven to the shared multiplier
//   mul_product   combinational product returned by the shared multiplier
//   rsp_valid     one-hot result valid, addressed to the owning requester
//   rsp_ready     per-requester result accept (only the owner's bit is used)
//   rsp_data      result, shared by all requesters
//   busy          high whenever the FSM is not in IDLE
//
// Optional feature (macro FMUL16_ARB_PERF_CNT_EN):
//   op_count      completed operations, wraps at 2^32
//   stall_count   RESP cycles spent waiting on the owner, saturates at 2^32-1
// ---------------------------------------------------------------------------
module fmul16_arbiter #(
  parameter  int NUM_REQ  = 4,
  localparam int REQ_ID_W = $clog2(NUM_REQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  output logic [15:0]           mul_a,
  output logic [15:0]           mul_b,
  input  logic [15:0]           mul_product,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [15:0]           rsp_data,
  output logic                  busy
`ifdef FMUL16_ARB_PERF_CNT_EN
  ,
  output logic [31:0]           op_count,
  output logic [31:0]           stall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } ArbState;

  ArbState               r_state;
  logic [REQ_ID_W-1:0]   r_rrPtr;
  logic [REQ_ID_W-1:0]   r_owner;
  logic [15:0]           r_mulA;
  logic [15:0]           r_mulB;
  logic [15:0]           r_rspData;
  logic [NUM_REQ-1:0]    r_rspValid;
  logic                  r_busy;

  logic                  w_found;
  logic [REQ_ID_W-1:0]   w_winner;
  logic [REQ_ID_W-1:0]   w_nextPtr;
  logic                  w_ownerReady;

  // Round-robin winner search. Offsets are walked from the far end back to
  // rr_ptr so that the last hit, the one closest to rr_ptr, wins without a
  // loop break. The index is kept one bit wider so the wrap past NUM_REQ-1
  // also works when NUM_REQ is not a power of two.
  always_comb begin
    logic [REQ_ID_W:0] idx;
    idx      = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, r_rrPtr} + (REQ_ID_W + 1)'(k);
      if (idx >= (REQ_ID_W + 1)'(NUM_REQ)) begin
        idx = idx - (REQ_ID_W + 1)'(NUM_REQ);
      end
      if (req_valid[idx[REQ_ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = idx[REQ_ID_W-1:0];
      end
    end
  end

  // The pointer moves to the slot just after the winner, wrapping to 0.
  assign w_nextPtr    = (w_winner == REQ_ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
  assign w_ownerReady = rsp_ready[r_owner];

  // Accept is offered only in IDLE and never while reset is held, so a
  // requester can never see an accept that the FSM then ignores.
  assign req_ready = (r_state == IDLE && w_found && !RST) ? (NUM_REQ'(1) << w_winner) : '0;

  // Main FSM. All outputs except req_ready come from registers. Operands are
  // sampled only on the accept edge and then held, including after the
  // operation, until the next grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_rrPtr    <= '0;
      r_owner    <= '0;
      r_mulA     <= '0;
      r_mulB     <= '0;
      r_rspData  <= '0;
      r_rspValid <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_mulA  <= req_a[16*w_winner +: 16];
            r_mulB  <= req_b[16*w_winner +: 16];
            r_owner <= w_winner;
            r_rrPtr <= w_nextPtr;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_rspData  <= mul_product;
          r_rspValid <= NUM_REQ'(1) << r_owner;
          r_state    <= RESP;
        end
        RESP: begin
          // Always return through IDLE so that every grant costs a full
          // arbitration cycle.
          if (w_ownerReady) begin
            r_rspValid <= '0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mul_a     = r_mulA;
  assign mul_b     = r_mulB;
  assign rsp_data  = r_rspData;
  assign rsp_valid = r_rspValid;
  assign busy      = r_busy;

`ifdef FMUL16_ARB_PERF_CNT_EN
  logic [31:0] r_opCount;
  logic [31:0] r_stallCount;

  // Performance counters. op_count wraps naturally. stall_count holds at its
  // maximum so a long stall is never reported as a short one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_opCount    <= '0;
      r_stallCount <= '0;
    end else if (r_state == RESP) begin
      if (w_ownerReady) begin
        r_opCount <= r_opCount + 32'd1;
      end else if (r_stallCount != 32'hFFFF_FFFF) begin
        r_stallCount <= r_stallCount + 32'd1;
      end
    end
  end

  assign op_count    = r_opCount;
  assign stall_count = r_stallCount;
`endif

endmodule

// File: tb/tb_fmul16_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fmul16_arbiter
//
// Directed bench for fmul16_arbiter with NUM_REQ=4. A small lookup-table
// multiplier stands in for the shared FP16 unit and holds hand-computed
// products. The stimulus pushes the expected response for each grant into a
// queue. An independent monitor pops that queue whenever a response shows up
// and also checks that rsp_valid and rsp_data stay stable until accepted.
// Build with +define+FMUL16_ARB_PERF_CNT_EN to include the counters.
// ---------------------------------------------------------------------------
module tb_fmul16_arbiter;

  logic        CLK;
  logic        RST;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_product;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [15:0] rsp_data;
  logic        busy;
`ifdef FMUL16_ARB_PERF_CNT_EN
  logic [31:0] op_count;
  logic [31:0] stall_count;
`endif

  typedef struct {
    int          id;
    logic [15:0] data;
  } ExpRsp;

  ExpRsp expQ[$];
  int    checks = 0;
  int    errors = 0;

  fmul16_arbiter #(.NUM_REQ(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .busy        (busy)
`ifdef FMUL16_ARB_PERF_CNT_EN
    ,
    .op_count    (op_count),
    .stall_count (stall_count)
`endif
  );

  // Free-running 10-time-unit clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Stand-in for the shared multiplier: a table of hand-computed FP16
  // products. Any other operand pair returns a^b, so it cannot match a
  // table entry by accident. 0x7C00*0x0000 returns 0xFFFF, a distinctive
  // NaN pattern, to show the arbiter forwards whatever the unit produces.
  function automatic logic [15:0] fakeMul(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_4000: fakeMul = 16'h4000;
      32'h3C00_3C00: fakeMul = 16'h3C00;
      32'h4000_4000: fakeMul = 16'h4400;
      32'h4000_4200: fakeMul = 16'h4600;
      32'h4200_4200: fakeMul = 16'h4880;
      32'h4400_4400: fakeMul = 16'h4C00;
      32'h7C00_0000: fakeMul = 16'hFFFF;
      32'h7C00_C000: fakeMul = 16'hFC00;
      default:       fakeMul = a ^ b;
    endcase
  endfunction

  always_comb mul_product = fakeMul(mul_a, mul_b);

  // Single comparison point. Every check and every failure goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic setOperands(input int idx, input logic [15:0] a, input logic [15:0] b);
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
  endtask

  // One complete operation, entered just after a clock edge with the DUT in
  // IDLE. It returns just after the edge that takes the DUT back to IDLE.
  // During a stall, only the owner's rsp_ready bit is held low, which shows
  // that the other bits are ignored. With scramble set, the winner's operands
  // are corrupted after the accept edge, which must not affect the product.
  task automatic applyStimulus(input logic [3:0] valid, input int expGrant,
                               input logic [15:0] expData, input int stallCycles,
                               input bit scramble);
    logic [3:0] grantMask;
    ExpRsp      e;
    grantMask = 4'b0001 << expGrant;
    req_valid = valid;
    rsp_ready = (stallCycles > 0) ? ~grantMask : 4'hF;
    @(negedge CLK);
    checkOutput("grant", 32'(req_ready), 32'(grantMask));
    checkOutput("idleBusy", 32'(busy), 32'h0);
    e.id   = expGrant;
    e.data = expData;
    expQ.push_back(e);
    @(posedge CLK); #1;
    if (scramble) begin
      setOperands(expGrant, 16'h1234, 16'h1234);
    end
    @(negedge CLK);
    checkOutput("issueReady", 32'(req_ready), 32'h0);
    checkOutput("issueBusy", 32'(busy), 32'h1);
    checkOutput("issueRspValid", 32'(rsp_valid), 32'h0);
    @(posedge CLK); #1;
    for (int s = 0; s < stallCycles; s++) begin
      @(negedge CLK);
      checkOutput("stallReady", 32'(req_ready), 32'h0);
      checkOutput("stallBusy", 32'(busy), 32'h1);
      @(posedge CLK); #1;
    end
    rsp_ready = 4'hF;
    @(posedge CLK); #1;
  endtask

  // Response monitor. On the first cycle of each response it pops the
  // expected entry and compares. On later cycles it requires the response to
  // be unchanged. A response is complete once the owner's ready is seen.
  initial begin
    logic        inResp;
    logic [3:0]  heldValid;
    logic [15:0] heldData;
    ExpRsp       e;
    inResp    = 1'b0;
    heldValid = '0;
    heldData  = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        inResp = 1'b0;
      end else if (rsp_valid != 4'b0000) begin
        if (!inResp) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedRsp", 32'(rsp_valid), 32'h0);
          end else begin
            e = expQ.pop_front();
            checkOutput("rspValid", 32'(rsp_valid), 32'(4'b0001 << e.id));
            checkOutput("rspData", 32'(rsp_data), 32'(e.data));
          end
          heldValid = rsp_valid;
          heldData  = rsp_data;
          inResp    = 1'b1;
        end else begin
          checkOutput("rspValidStable", 32'(rsp_valid), 32'(heldValid));
          checkOutput("rspDataStable", 32'(rsp_data), 32'(heldData));
        end
        if ((rsp_valid & rsp_ready) != 4'b0000) begin
          inResp = 1'b0;
        end
      end
    end
  end

  // Watchdog. The directed sequence is fixed-length, so this only fires if
  // something unexpected stalls the bench.
  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    RST       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;

    // Reset state.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rstReqReady", 32'(req_ready), 32'h0);
    checkOutput("rstRspValid", 32'(rsp_valid), 32'h0);
    checkOutput("rstBusy", 32'(busy), 32'h0);
    checkOutput("rstMulA", 32'(mul_a), 32'h0);
    checkOutput("rstMulB", 32'(mul_b), 32'h0);
    checkOutput("rstRspData", 32'(rsp_data), 32'h0);
`ifdef FMUL16_ARB_PERF_CNT_EN
    checkOutput("rstOpCount", op_count, 32'h0);
    checkOutput("rstStallCount", stall_count, 32'h0);
`endif
    @(posedge CLK); #1;
    RST = 1'b0;

    // Single op 1.0*2.0 = 2.0. Operands are corrupted after the accept edge.
    $display("[TB] single op");
    setOperands(0, 16'h3C00, 16'h4000);
    applyStimulus(4'b0001, 0, 16'h4000, 0, 1'b1);
    req_valid = 4'b0000;
    @(negedge CLK);
    checkOutput("mulAHeld", 32'(mul_a), 32'h3C00);
    checkOutput("mulBHeld", 32'(mul_b), 32'h4000);
    @(posedge CLK); #1;

    // Requester 3 (4.0*4.0=16.0) moves the pointer back to 0.
    setOperands(3, 16'h4400, 16'h4400);
    applyStimulus(4'b1000, 3, 16'h4C00, 0, 1'b0);

    // Round-robin with all requesters continuously valid.
    $display("[TB] round robin");
    setOperands(0, 16'h3C00, 16'h3C00);
    setOperands(1, 16'h4000, 16'h4000);
    setOperands(2, 16'h4000, 16'h4200);
    setOperands(3, 16'h4200, 16'h4200);
    applyStimulus(4'b1111, 0, 16'h3C00, 0, 1'b0);
    applyStimulus(4'b1111, 1, 16'h4400, 0, 1'b0);
    applyStimulus(4'b1111, 2, 16'h4600, 0, 1'b0);
    applyStimulus(4'b1111, 3, 16'h4880, 0, 1'b0);
    applyStimulus(4'b1111, 0, 16'h3C00, 0, 1'b0);

    // Owner back-pressures for five cycles while everyone keeps requesting.
    $display("[TB] backpressure");
    applyStimulus(4'b1111, 1, 16'h4400, 5, 1'b0);
`ifdef FMUL16_ARB_PERF_CNT_EN
    checkOutput("stallCount", stall_count, 32'd5);
    checkOutput("opCount", op_count, 32'd8);
`endif

    // Special values pass through untouched. Pointer is 2 here.
    $display("[TB] special values and wrap");
    setOperands(2, 16'h7C00, 16'h0000);
    applyStimulus(4'b0100, 2, 16'hFFFF, 0, 1'b0);
    // Pointer 3, requests 0110: the scan wraps past 3 and 0 to grant 1.
    applyStimulus(4'b0110, 1, 16'h4400, 0, 1'b0);
    // Pointer now 2, so 0111 must grant 2 rather than 0.
    setOperands(2, 16'h7C00, 16'hC000);
    applyStimulus(4'b0111, 2, 16'hFC00, 0, 1'b0);

    // Reset during ISSUE. The pointer is 3 before reset.
    $display("[TB] reset mid-op");
    setOperands(2, 16'h4000, 16'h4200);
    req_valid = 4'b0100;
    rsp_ready = 4'hF;
    @(negedge CLK);
    checkOutput("preRstGrant", 32'(req_ready), 32'h4);
    @(posedge CLK); #1;
    checkOutput("issueBeforeRst", 32'(busy), 32'h1);
    RST       = 1'b1;
    req_valid = 4'b0000;
    #1;
    checkOutput("midRstRspValid", 32'(rsp_valid), 32'h0);
    checkOutput("midRstBusy", 32'(busy), 32'h0);
    checkOutput("midRstMulA", 32'(mul_a), 32'h0);
    checkOutput("midRstMulB", 32'(mul_b), 32'h0);
    checkOutput("midRstReqReady", 32'(req_ready), 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    // Pointer restarted at 0: 1001 grants 0, then 1000 grants 3.
    applyStimulus(4'b1001, 0, 16'h3C00, 0, 1'b0);
    applyStimulus(4'b1000, 3, 16'h4880, 0, 1'b0);
`ifdef FMUL16_ARB_PERF_CNT_EN
    checkOutput("opCountAfterRst", op_count, 32'd2);
    checkOutput("stallCountAfterRst", stall_count, 32'd0);
`endif

    req_valid = 4'b0000;
    for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
      @(posedge CLK);
    end
    checkOutput("queueDrained", 32'(expQ.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
